// File: rtl/ins_prefetch.sv
// Instruction prefetch buffer. It keeps a small FIFO of sequential
// instruction words ahead of the core. A fetch that does not match the
// current stream redirects prefetching. The memory side allows only one
// outstanding read at a time.
module ins_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        exIns_ren,
  input  logic [31:0] exIns_addr,
  output logic        exIns_valid,
  output logic [31:0] exIns_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [31:0] r_fifo [DEPTH];
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [AW:0]   r_count;

  logic [31:0] r_headAddr;
  logic [31:0] r_fetchAddr;
  logic [31:0] r_memAddr;
  logic        r_streamValid;
  logic        r_drop;

  logic [31:0] w_targetAddr;
  logic        w_match;
  logic        w_hit;
  logic        w_pending;
  logic        w_miss;
  logic        w_push;
  logic        w_issue;
  logic        w_accept;
  logic        w_hasSpace;

  // The low two address bits never take part in matching.
  assign w_targetAddr = exIns_addr & 32'hFFFF_FFFC;
  assign w_match      = (w_targetAddr == r_headAddr);
  assign w_hit        = exIns_ren && (r_count != '0) && w_match;
  assign w_pending    = exIns_ren && (r_count == '0) && r_streamValid && w_match;
  assign w_miss       = exIns_ren && !w_hit && !w_pending;
  assign w_hasSpace   = (r_count < (AW+1)'(DEPTH));

  // A redirect in the same cycle as the return discards the returned word.
  assign w_push = (r_state == ST_WAIT) && mem_rvalid && !r_drop && !w_miss;

  assign exIns_valid = w_hit;
  assign exIns_in    = w_hit ? r_fifo[r_rdPtr] : 32'h0;
  assign mem_req     = (r_state == ST_REQ);
  assign mem_addr    = r_memAddr;

  // Memory FSM next state. An issue is held back during a redirect so that
  // the first request after it already targets the new stream.
  always_comb begin
    w_stateNext = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_streamValid && w_hasSpace && !w_miss) begin
          w_stateNext = ST_REQ;
          w_issue     = 1'b1;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          w_stateNext = ST_WAIT;
          w_accept    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Memory FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Stream addresses, request address and the drop flag for stale reads.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_headAddr    <= 32'h0;
      r_fetchAddr   <= 32'h0;
      r_memAddr     <= 32'h0;
      r_streamValid <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      if (w_issue) begin
        r_memAddr <= r_fetchAddr;
      end
      if (w_miss) begin
        r_headAddr    <= w_targetAddr;
        r_fetchAddr   <= w_targetAddr;
        r_streamValid <= 1'b1;
      end else begin
        if (w_hit) begin
          r_headAddr <= r_headAddr + 32'd4;
        end
        if (w_accept && !r_drop) begin
          r_fetchAddr <= r_fetchAddr + 32'd4;
        end
      end
      if ((r_state == ST_WAIT) && mem_rvalid) begin
        r_drop <= 1'b0;
      end else if (w_miss && (r_state != ST_IDLE)) begin
        r_drop <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy. A redirect flushes everything.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (w_miss) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_hit) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_hit})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO word storage. Contents need no reset because occupancy guards them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wrPtr] <= mem_rdata;
    end
  end

endmodule
